rom_seq_ctrl: RTL and testbench
===============================

Name: rom_seq_ctrl

Overview:
- Sequencing controller for a generic synchronous ROM (1-cycle read latency) that drives the LED bank.
- Walks ROM addresses 0..last_addr and latches each word onto the LED outputs.
- Holds each word for a programmable number of cycles.
- Supports play, stop, single-step and loop, so the LED sequencer can be commanded at run time instead of free-running.

Parameters:
AW, 5, ROM address width
DW, 5, ROM data width (LED count)
CW, 24, width of hold-delay counter

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
cmd_play  input  1  start/restart continuous playback from address 0 (level-sampled each cycle)
cmd_stop  input  1  abort playback, return to IDLE
cmd_step  input  1  in IDLE only: fetch and show one word, then advance address
loop  input  1  1 = wrap to address 0 after last_addr; 0 = stop after last_addr
last_addr  input  AW  final address of sequence, sampled on play/step acceptance
delay  input  CW  hold cycles per word, sampled in LOAD
rom_addr  output  AW  address to ROM
rom_data  input  DW  ROM read data, valid one cycle after rom_addr
leds  output  DW  latched ROM word
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when a non-loop sequence completes

Behaviour:
- Reset (rstn=0 at a clock edge): state=IDLE, rom_addr=0, leds=0, busy=0, done=0, hold counter=0, step pointer=0, latched last_addr=0.
- States: IDLE, FETCH, LOAD, HOLD.
- Command priority per cycle: cmd_stop > cmd_play > cmd_step.
- IDLE + cmd_play: latch last_addr, rom_addr<=0, go to FETCH.
- IDLE + cmd_step: latch last_addr, rom_addr<=step pointer, go to FETCH, set step flag.
- FETCH (1 cycle): ROM registers data; go to LOAD.
- LOAD (1 cycle):
  - leds<=rom_data.
  - hold counter<=max(delay,1)-1, so delay=0 behaves as 1.
  - Non-step: go to HOLD.
  - Step flag set: step pointer<=(rom_addr==last_addr)?0:rom_addr+1, clear step flag, go to IDLE. No done pulse.
- HOLD: decrement counter each cycle. When counter==0:
  - rom_addr<last_addr: rom_addr+1, go to FETCH.
  - rom_addr==last_addr, loop=1: rom_addr<=0, go to FETCH.
  - rom_addr==last_addr, loop=0: pulse done, go to IDLE; rom_addr and leds keep last values.
- Timing:
  - Per-word period in playback = max(delay,1)+2 cycles.
  - Play accepted at edge k: rom_addr=0 after k; leds=rom[0] after edge k+2.
- cmd_stop in any non-IDLE state: go to IDLE next edge, rom_addr<=0, step pointer<=0. leds hold their last value; no done pulse.
- cmd_play while busy: restart from address 0 at the next edge, re-latch last_addr, no done pulse.
- cmd_step while busy: ignored.
- loop is sampled live at the HOLD terminal cycle. last_addr changes mid-sequence are ignored until the next acceptance.
- last_addr=0: single-word sequence. With loop=1 it re-fetches address 0 every max(delay,1)+2 cycles.
- All outputs are registered; rstn overrides every command in the same cycle.

Optional Feature:
- Macro: ROM_SEQ_CTRL_PAUSE_EN.
- Defined: adds input cmd_pause (1 bit).
  - While cmd_pause=1 in HOLD, the hold counter freezes and the state stays HOLD.
  - In FETCH/LOAD the current FETCH/LOAD completes, then the block freezes in HOLD.
  - cmd_stop and cmd_play still override pause.
  - busy stays 1.
- Undefined: no cmd_pause port, HOLD always counts.

Test Plan:
- Reset then idle: rstn low 2 cycles, release, no commands -> rom_addr=0, leds=0, busy=0, done=0 for 10 cycles.
- One-shot play: ROM=[0x01,0x02,0x04,0x08], last_addr=3, loop=0, delay=2, pulse cmd_play at cycle 0:
  - leds=0x01 after cycle 2, 0x02 after cycle 6, 0x04 after cycle 10, 0x08 after cycle 14.
  - done=1 exactly one cycle at cycle 16, then busy=0.
- Loop and delay=0: same ROM, loop=1, delay=0 -> leds cycles 0x01,0x02,0x04,0x08,0x01 with a 3-cycle period each; done never asserts over 40 cycles.
- Step mode: last_addr=1, four cmd_step pulses spaced 5 cycles apart -> leds 0x01,0x02,0x01,0x02; busy high 2 cycles per step; done=0.
- Stop and restart: play with delay=5, cmd_stop during word 2 -> IDLE next edge, rom_addr=0, leds=0x02 held; cmd_play 3 cycles later -> leds=0x01 two cycles after acceptance.
- Reset mid-HOLD and, with ROM_SEQ_CTRL_PAUSE_EN, pause:
  - rstn=0 during HOLD -> all reset values next edge.
  - cmd_pause held 10 cycles in HOLD -> leds and counter unchanged; the word period extends by exactly 10 cycles.

Source files
------------

// File: rtl/rom_seq_ctrl.sv
// ROM-driven LED sequencer: play / stop / single-step / loop over addresses 0..last_addr.
// Optional run-time pause input is enabled by defining ROM_SEQ_CTRL_PAUSE_EN.
module rom_seq_ctrl #(
    parameter int AW = 5,
    parameter int DW = 5,
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_play,
    input  logic          cmd_stop,
    input  logic          cmd_step,
`ifdef ROM_SEQ_CTRL_PAUSE_EN
    input  logic          cmd_pause,
`endif
    input  logic          loop,
    input  logic [AW-1:0] last_addr,
    input  logic [CW-1:0] delay,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] leds,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD} state_t;

    state_t        r_state, w_next_state;
    logic [AW-1:0] r_rom_addr, w_rom_addr_nxt;
    logic [AW-1:0] r_step_ptr, w_step_ptr_nxt;
    logic [AW-1:0] r_last,     w_last_nxt;
    logic [DW-1:0] r_leds,     w_leds_nxt;
    logic [CW-1:0] r_cnt,      w_cnt_nxt;
    logic          r_step,     w_step_nxt;
    logic          r_busy,     w_busy_nxt;
    logic          r_done,     w_done_nxt;
    logic          w_pause;
    logic          w_at_last;
    logic [CW-1:0] w_hold;

`ifdef ROM_SEQ_CTRL_PAUSE_EN
    assign w_pause = cmd_pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_at_last = (r_rom_addr == r_last);
    // delay of zero is treated as one hold cycle
    assign w_hold    = (delay == '0) ? '0 : delay - CW'(1);

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == S_IDLE) begin
            if (!cmd_stop && (cmd_play || cmd_step))
                w_next_state = S_FETCH;
        end else if (cmd_stop) begin
            w_next_state = S_IDLE;
        end else if (cmd_play) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: w_next_state = S_LOAD;
                S_LOAD:  w_next_state = r_step ? S_IDLE : S_HOLD;
                S_HOLD: begin
                    if (!w_pause && r_cnt == '0)
                        w_next_state = (!w_at_last || loop) ? S_FETCH : S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rom_addr_nxt = r_rom_addr;
        w_step_ptr_nxt = r_step_ptr;
        w_last_nxt     = r_last;
        w_leds_nxt     = r_leds;
        w_cnt_nxt      = r_cnt;
        w_step_nxt     = r_step;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = (w_next_state != S_IDLE);
        if (r_state == S_IDLE) begin
            if (!cmd_stop) begin
                if (cmd_play) begin
                    w_last_nxt     = last_addr;
                    w_rom_addr_nxt = '0;
                    w_step_nxt     = 1'b0;
                end else if (cmd_step) begin
                    w_last_nxt     = last_addr;
                    w_rom_addr_nxt = r_step_ptr;
                    w_step_nxt     = 1'b1;
                end
            end
        end else if (cmd_stop) begin
            w_rom_addr_nxt = '0;
            w_step_ptr_nxt = '0;
            w_step_nxt     = 1'b0;
        end else if (cmd_play) begin
            w_last_nxt     = last_addr;
            w_rom_addr_nxt = '0;
            w_step_nxt     = 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    w_leds_nxt = rom_data;
                    w_cnt_nxt  = w_hold;
                    if (r_step) begin
                        w_step_ptr_nxt = w_at_last ? '0 : r_rom_addr + AW'(1);
                        w_step_nxt     = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!w_pause) begin
                        if (r_cnt != '0)     w_cnt_nxt      = r_cnt - CW'(1);
                        else if (!w_at_last) w_rom_addr_nxt = r_rom_addr + AW'(1);
                        else if (loop)       w_rom_addr_nxt = '0;
                        else                 w_done_nxt     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rom_addr <= '0;
            r_step_ptr <= '0;
            r_last     <= '0;
            r_leds     <= '0;
            r_cnt      <= '0;
            r_step     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rom_addr <= w_rom_addr_nxt;
            r_step_ptr <= w_step_ptr_nxt;
            r_last     <= w_last_nxt;
            r_leds     <= w_leds_nxt;
            r_cnt      <= w_cnt_nxt;
            r_step     <= w_step_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign rom_addr = r_rom_addr;
    assign leds     = r_leds;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Directed bench for rom_seq_ctrl with a 1-cycle-latency ROM model.
// Pause scenario runs only when ROM_SEQ_CTRL_PAUSE_EN is defined.
module tb_rom_seq_ctrl;

    localparam int AW = 5;
    localparam int DW = 5;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_play, cmd_stop, cmd_step;
    logic          cmd_pause;
    logic          loop;
    logic [AW-1:0] last_addr;
    logic [CW-1:0] delay;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] leds;
    logic          busy, done;

    logic [DW-1:0] rom [32];
    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    int unsigned   done_cnt;
    int unsigned   w;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    rom_seq_ctrl #(.AW(AW), .DW(DW), .CW(CW)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_play  (cmd_play),
        .cmd_stop  (cmd_stop),
        .cmd_step  (cmd_step),
`ifdef ROM_SEQ_CTRL_PAUSE_EN
        .cmd_pause (cmd_pause),
`endif
        .loop      (loop),
        .last_addr (last_addr),
        .delay     (delay),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .leds      (leds),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 5'h10;
        rom[0] = 5'h01; rom[1] = 5'h02; rom[2] = 5'h04; rom[3] = 5'h08;
        rstn = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0; cmd_pause = 1'b0;
        loop = 1'b0; last_addr = '0; delay = '0;

        // reset then idle
        tick(); tick();
        check("reset_state", {rom_addr, leds, busy, done}, 0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", {rom_addr, leds, busy, done}, 0);
        end

        // one-shot play, delay=2: period 4, done at edge 16
        last_addr = 5'd3; loop = 1'b0; delay = 24'd2;
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        check("play_addr0", rom_addr, 0);
        check("play_busy0", busy, 1);
        last_addr = 5'd7;
        for (int n = 1; n <= 18; n++) begin
            tick();
            w = (n < 2) ? 0 : (((n - 2) / 4 > 3) ? 3 : (n - 2) / 4);
            check("oneshot_leds", leds, (n < 2) ? 0 : rom[w]);
            check("oneshot_addr", rom_addr, (n / 4 > 3) ? 3 : n / 4);
            check("oneshot_busy", busy, (n < 16) ? 1 : 0);
            check("oneshot_done", done, (n == 16) ? 1 : 0);
        end

        // loop with delay=0: period 3, no done
        last_addr = 5'd3; loop = 1'b1; delay = 24'd0;
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= 41; n++) begin
            tick();
            done_cnt += done;
            if (n >= 2) check("loop_leds", leds, rom[((n - 2) / 3) % 4]);
        end
        check("loop_no_done", done_cnt, 0);
        check("loop_busy", busy, 1);
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
        check("loop_stop_busy", busy, 0);
        check("loop_stop_addr", rom_addr, 0);

        // single-step, last_addr=1
        last_addr = 5'd1; loop = 1'b0; delay = 24'd4;
        for (int s = 0; s < 4; s++) begin
            cmd_step = 1'b1; tick(); cmd_step = 1'b0;
            check("step_busy_e0", busy, 1);
            tick();
            check("step_busy_e1", busy, 1);
            tick();
            check("step_busy_e2", busy, 0);
            check("step_leds", leds, rom[s % 2]);
            check("step_addr", rom_addr, s % 2);
            check("step_done", done, 0);
            tick(); tick();
        end

        // stop during word 1 (leds=0x02), restart 3 cycles later
        last_addr = 5'd3; loop = 1'b0; delay = 24'd5;
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        for (int n = 1; n <= 9; n++) tick();
        check("stop_pre_leds", leds, 5'h02);
        tick();
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_addr", rom_addr, 0);
        check("stop_leds", leds, 5'h02);
        check("stop_done", done, 0);
        tick(); tick();
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        check("restart_busy", busy, 1);
        tick();
        check("restart_leds_e1", leds, 5'h02);
        tick();
        check("restart_leds_e2", leds, 5'h01);

        // reset during HOLD wins over a same-cycle play
        tick();
        rstn = 1'b0; cmd_play = 1'b1; tick();
        check("hold_reset", {rom_addr, leds, busy, done}, 0);
        rstn = 1'b1; cmd_play = 1'b0; tick();
        check("post_reset_idle", busy, 0);

`ifdef ROM_SEQ_CTRL_PAUSE_EN
        // pause 10 cycles in HOLD of word 0 stretches that word by 10
        last_addr = 5'd3; loop = 1'b0; delay = 24'd2;
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        tick(); tick(); tick();
        cmd_pause = 1'b1;
        for (int n = 4; n <= 13; n++) tick();
        cmd_pause = 1'b0;
        check("pause_leds", leds, 5'h01);
        check("pause_addr", rom_addr, 0);
        check("pause_busy", busy, 1);
        tick(); tick();
        check("pause_leds_e15", leds, 5'h01);
        tick();
        check("pause_leds_e16", leds, 5'h02);
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
